// File: rtl/ldst_mem_sequencer.sv
// ldst_mem_sequencer
//   Takes the head entry of the in-order load/store buffer and runs it on the
//   single data-memory port, with at most one access in flight.
//   - A load waits for dmem_resp, then broadcasts its result on the CDB until
//     the CDB grants it a slot.
//   - A store is issued only when its entry is also the ROB head. It retires
//     on dmem_resp and pulses store_done.
//   - head_pop pulses once for each entry that retires from this block.
// Ports
//   clk, flush                  clock; sync active-high reset / pipeline flush
//   head_*                      load/store buffer head entry fields
//   rob_head_valid/_tag         current ROB head
//   dmem_read/write/addr/wdata/byte_en, dmem_rdata/resp   data memory port
//   cdb_req/tag/data, cdb_grant                           CDB request/grant
//   store_done, head_pop, busy  retire pulses and activity flag
module ldst_mem_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              head_valid,
    input  logic              head_is_store,
    input  logic              head_byte,
    input  logic              head_addr_rdy,
    input  logic              head_data_rdy,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [DATA_W-1:0] head_data,
    input  logic [TAG_W-1:0]  head_tag,
    input  logic              rob_head_valid,
    input  logic [TAG_W-1:0]  rob_head_tag,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_en,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant,
    output logic              store_done,
    output logic              head_pop,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        CDB  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic [TAG_W-1:0]  tag_q;
    logic              byte_q;
    logic              store_q;
    logic [DATA_W-1:0] ld_data_q;

    logic              issue_ok;
    logic              issue;
    logic              mem_done;
    logic [7:0]        ld_byte;

    // A store may only go to memory when it is non-speculative, i.e. it is the
    // ROB head. A load only needs its address.
    assign issue_ok = head_valid & head_addr_rdy &
                      (~head_is_store |
                       (head_data_rdy & rob_head_valid & (rob_head_tag == head_tag)));
    assign issue    = (state_q == IDLE) & issue_ok;
    assign mem_done = (state_q == MEM) & dmem_resp;
    assign ld_byte  = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_ok)  state_d = MEM;
            MEM:     if (dmem_resp) state_d = store_q ? IDLE : CDB;
            CDB:     if (cdb_grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The head entry is latched at issue, so later changes to the buffer head
    // cannot disturb an access that is in flight.
    always_ff @(posedge clk) begin
        if (flush) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            tag_q     <= '0;
            byte_q    <= 1'b0;
            store_q   <= 1'b0;
            ld_data_q <= '0;
        end else begin
            if (issue) begin
                addr_q  <= head_addr;
                tag_q   <= head_tag;
                byte_q  <= head_byte;
                store_q <= head_is_store;
                wdata_q <= head_byte ? {(DATA_W/8){head_data[7:0]}} : head_data;
                be_q    <= (head_is_store & head_byte) ?
                           (head_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            end
            if (mem_done && !store_q) begin
                ld_data_q <= byte_q ? {{(DATA_W-8){ld_byte[7]}}, ld_byte} : dmem_rdata;
            end
        end
    end

    // Every memory-port and CDB output comes from flops. head_pop and
    // store_done are the only outputs that depend combinationally on inputs.
    // They are gated by flush so that an abandoned entry never retires.
    assign dmem_read    = (state_q == MEM) & ~store_q;
    assign dmem_write   = (state_q == MEM) &  store_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_byte_en = be_q;
    assign cdb_req      = (state_q == CDB);
    assign cdb_tag      = tag_q;
    assign cdb_data     = ld_data_q;
    assign store_done   = ~flush & mem_done & store_q;
    assign head_pop     = ~flush & ((mem_done & store_q) | ((state_q == CDB) & cdb_grant));
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ldst_mem_sequencer.sv
module tb_ldst_mem_sequencer;

    logic        clk = 1'b0;
    logic        flush;
    logic        head_valid, head_is_store, head_byte, head_addr_rdy, head_data_rdy;
    logic [15:0] head_addr, head_data;
    logic [2:0]  head_tag;
    logic        rob_head_valid;
    logic [2:0]  rob_head_tag;
    logic        dmem_read, dmem_write;
    logic [15:0] dmem_addr, dmem_wdata;
    logic [1:0]  dmem_byte_en;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        cdb_req;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_grant;
    logic        store_done, head_pop, busy;

    int passed = 0;
    int total  = 0;
    int pop_count = 0;

    // Scoreboards: load results {tag, data}; store accesses {addr, wdata, be}.
    logic [18:0] ld_q[$];
    logic [33:0] st_q[$];

    ldst_mem_sequencer #(.DATA_W(16), .ADDR_W(16), .TAG_W(3)) dut (
        .clk(clk), .flush(flush),
        .head_valid(head_valid), .head_is_store(head_is_store), .head_byte(head_byte),
        .head_addr_rdy(head_addr_rdy), .head_data_rdy(head_data_rdy),
        .head_addr(head_addr), .head_data(head_data), .head_tag(head_tag),
        .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
        .store_done(store_done), .head_pop(head_pop), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (head_pop === 1'b1) pop_count <= pop_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_load(input logic [15:0] a, input logic b, input logic [2:0] t,
                           input logic [15:0] rd, input int lat, input int glat);
        logic [15:0] exp_d;
        logic [18:0] e;
        int rcnt;
        exp_d = b ? (a[0] ? {{8{rd[15]}}, rd[15:8]} : {{8{rd[7]}}, rd[7:0]}) : rd;
        ld_q.push_back({t, exp_d});
        head_valid = 1; head_is_store = 0; head_byte = b; head_addr = a;
        head_tag = t; head_addr_rdy = 1; head_data_rdy = 0;
        rcnt = 0;
        @(negedge clk);
        total++;
        if (dmem_read !== 1'b1 || dmem_addr !== a || dmem_byte_en !== 2'b11 || dmem_write !== 1'b0)
            $display("FAIL ld_issue: read=%b write=%b addr=%h be=%b, required read=1 write=0 addr=%h be=11",
                     dmem_read, dmem_write, dmem_addr, dmem_byte_en, a);
        else passed++;
        for (int i = 0; i < lat; i++) begin
            if (dmem_read === 1'b1) rcnt++;
            head_addr = ~a;            // busy: head changes must be ignored
            @(negedge clk);
        end
        dmem_resp = 1; dmem_rdata = rd;
        #1;
        if (dmem_read === 1'b1 && dmem_addr === a) rcnt++;
        total++;
        if (rcnt !== lat + 1 || head_pop !== 1'b0)
            $display("FAIL ld_hold: read cycles=%0d pop=%b, required %0d and pop=0", rcnt, head_pop, lat + 1);
        else passed++;
        @(negedge clk);
        dmem_resp = 0; dmem_rdata = 16'h0;
        total++;
        if (dmem_read !== 1'b0 || cdb_req !== 1'b1)
            $display("FAIL ld_to_cdb: read=%b cdb_req=%b, required 0 and 1", dmem_read, cdb_req);
        else passed++;
        for (int i = 0; i < glat; i++) begin
            @(negedge clk);
            total++;
            if (cdb_req !== 1'b1 || head_pop !== 1'b0)
                $display("FAIL cdb_hold: cdb_req=%b pop=%b, required 1 and 0", cdb_req, head_pop);
            else passed++;
        end
        cdb_grant = 1;
        #1;
        e = ld_q.pop_front();
        total++;
        if (head_pop !== 1'b1 || store_done !== 1'b0 || cdb_tag !== e[18:16] || cdb_data !== e[15:0])
            $display("FAIL ld_result: pop=%b sd=%b tag=%0d data=%h, required pop=1 sd=0 tag=%0d data=%h",
                     head_pop, store_done, cdb_tag, cdb_data, e[18:16], e[15:0]);
        else passed++;
        @(negedge clk);
        cdb_grant = 0; head_valid = 0;
        total++;
        if (cdb_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL ld_retire: cdb_req=%b busy=%b, required 0 and 0", cdb_req, busy);
        else passed++;
    endtask

    task automatic do_store(input logic [15:0] a, input logic b, input logic [15:0] d,
                            input logic [2:0] t, input int lat);
        logic [33:0] e;
        st_q.push_back({a, (b ? {d[7:0], d[7:0]} : d), (b ? (a[0] ? 2'b10 : 2'b01) : 2'b11)});
        head_valid = 1; head_is_store = 1; head_byte = b; head_addr = a; head_data = d;
        head_tag = t; head_addr_rdy = 1; head_data_rdy = 1;
        rob_head_valid = 1; rob_head_tag = t;
        @(negedge clk);
        e = st_q.pop_front();
        total++;
        if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_addr !== e[33:18] ||
            dmem_wdata !== e[17:2] || dmem_byte_en !== e[1:0])
            $display("FAIL st_issue: write=%b read=%b addr=%h wdata=%h be=%b, required 1 0 %h %h %b",
                     dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_byte_en, e[33:18], e[17:2], e[1:0]);
        else passed++;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            total++;
            if (dmem_write !== 1'b1 || dmem_wdata !== e[17:2])
                $display("FAIL st_hold: write=%b wdata=%h, required 1 %h", dmem_write, dmem_wdata, e[17:2]);
            else passed++;
        end
        dmem_resp = 1;
        #1;
        total++;
        if (store_done !== 1'b1 || head_pop !== 1'b1 || cdb_tag !== t || dmem_write !== 1'b1)
            $display("FAIL st_done: sd=%b pop=%b tag=%0d write=%b, required 1 1 %0d 1",
                     store_done, head_pop, cdb_tag, dmem_write, t);
        else passed++;
        @(negedge clk);
        dmem_resp = 0; head_valid = 0;
        total++;
        if (dmem_write !== 1'b0 || busy !== 1'b0 || cdb_req !== 1'b0 || store_done !== 1'b0)
            $display("FAIL st_retire: write=%b busy=%b cdb_req=%b sd=%b, required all 0",
                     dmem_write, busy, cdb_req, store_done);
        else passed++;
    endtask

    task automatic test_reset();
        flush = 1; head_valid = 1; head_is_store = 0; head_byte = 0; head_addr_rdy = 1;
        head_data_rdy = 0; head_addr = 16'h1234; head_data = 16'h0; head_tag = 3'd1;
        rob_head_valid = 0; rob_head_tag = 3'd0; dmem_rdata = 16'h0; dmem_resp = 1; cdb_grant = 1;
        @(negedge clk); @(negedge clk);
        total++;
        if (dmem_read !== 0 || dmem_write !== 0 || cdb_req !== 0 || busy !== 0 || head_pop !== 0 ||
            store_done !== 0 || dmem_addr !== 16'h0 || cdb_tag !== 3'd0 || cdb_data !== 16'h0)
            $display("FAIL reset: read=%b write=%b cdb_req=%b busy=%b pop=%b sd=%b addr=%h tag=%0d data=%h, required all 0",
                     dmem_read, dmem_write, cdb_req, busy, head_pop, store_done, dmem_addr, cdb_tag, cdb_data);
        else passed++;
        head_valid = 0; dmem_resp = 0; cdb_grant = 0;
        @(negedge clk);
        flush = 0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        int p0 = pop_count;
        do_load(16'h0040, 1'b0, 3'd1, 16'hBEEF, 3, 2);
        total++;
        if (pop_count - p0 !== 1) $display("FAIL word_load_pops: %0d, required 1", pop_count - p0);
        else passed++;
    endtask

    task automatic test_byte_loads();
        do_load(16'h0041, 1'b1, 3'd2, 16'h80AA, 1, 0);
        do_load(16'h0040, 1'b1, 3'd3, 16'h80AA, 0, 1);
        do_load(16'h0041, 1'b1, 3'd4, 16'h7F01, 0, 0);
    endtask

    task automatic test_store_rob_gate();
        head_valid = 1; head_is_store = 1; head_byte = 1; head_addr = 16'h0043;
        head_data = 16'h1234; head_tag = 3'd5; head_addr_rdy = 1; head_data_rdy = 1;
        rob_head_valid = 1; rob_head_tag = 3'd2;
        repeat (3) @(negedge clk);
        total++;
        if (dmem_write !== 1'b0 || busy !== 1'b0)
            $display("FAIL st_rob_gate: write=%b busy=%b, required 0 0", dmem_write, busy);
        else passed++;
        do_store(16'h0043, 1'b1, 16'h1234, 3'd5, 1);
        do_store(16'h0080, 1'b0, 16'hA5C3, 3'd6, 0);
        do_store(16'h0042, 1'b1, 16'h00F7, 3'd7, 0);
    endtask

    task automatic test_addr_wait();
        head_valid = 1; head_is_store = 0; head_byte = 0; head_addr = 16'h0100;
        head_tag = 3'd2; head_addr_rdy = 0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (dmem_read !== 1'b0 || busy !== 1'b0)
                $display("FAIL addr_wait: read=%b busy=%b, required 0 0", dmem_read, busy);
            else passed++;
        end
        do_load(16'h0100, 1'b0, 3'd2, 16'h1357, 0, 0);
    endtask

    task automatic test_flush();
        int p0 = pop_count;
        head_valid = 1; head_is_store = 0; head_byte = 0; head_addr = 16'h0200;
        head_tag = 3'd3; head_addr_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (dmem_read !== 1'b1)
            $display("FAIL flush_pre: read=%b, required 1", dmem_read);
        else passed++;
        flush = 1; head_valid = 0;
        @(negedge clk);
        flush = 0;
        total++;
        if (dmem_read !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_abandon: read=%b busy=%b, required 0 0", dmem_read, busy);
        else passed++;
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 16'hDEAD;
        #1;
        total++;
        if (head_pop !== 1'b0 || store_done !== 1'b0)
            $display("FAIL flush_late_resp: pop=%b sd=%b, required 0 0", head_pop, store_done);
        else passed++;
        @(negedge clk);
        dmem_resp = 0;
        total++;
        if (cdb_req !== 1'b0 || busy !== 1'b0 || pop_count !== p0)
            $display("FAIL flush_after: cdb_req=%b busy=%b pops=%0d, required 0 0 0",
                     cdb_req, busy, pop_count - p0);
        else passed++;
    endtask

    task automatic test_flush_cdb();
        int p0 = pop_count;
        head_valid = 1; head_is_store = 0; head_byte = 0; head_addr = 16'h0300;
        head_tag = 3'd4; head_addr_rdy = 1;
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 16'h4242;
        @(negedge clk);
        dmem_resp = 0;
        flush = 1; cdb_grant = 1; head_valid = 0;
        #1;
        total++;
        if (head_pop !== 1'b0)
            $display("FAIL flush_cdb_pop: pop=%b, required 0", head_pop);
        else passed++;
        @(negedge clk);
        flush = 0; cdb_grant = 0;
        total++;
        if (cdb_req !== 1'b0 || busy !== 1'b0 || pop_count !== p0)
            $display("FAIL flush_cdb_after: cdb_req=%b busy=%b pops=%0d, required 0 0 0",
                     cdb_req, busy, pop_count - p0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int p0 = pop_count;
        do_load(16'h0400, 1'b0, 3'd1, 16'hCAFE, 0, 0);
        do_store(16'h0402, 1'b0, 16'h5A5A, 3'd2, 0);
        total++;
        if (pop_count - p0 !== 2) $display("FAIL b2b_pops: %0d, required 2", pop_count - p0);
        else passed++;
        total++;
        if (ld_q.size() !== 0 || st_q.size() !== 0)
            $display("FAIL scoreboard_empty: ld=%0d st=%0d, required 0 0", ld_q.size(), st_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_store_rob_gate();
        test_addr_wait();
        test_flush();
        test_flush_cdb();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
